// File: rtl/pio_out_blink_pkg.sv
// Shared register map for the blinking output PIO.
package pio_out_blink_pkg;

  localparam int unsigned ADDR_W = 3;

  localparam logic [ADDR_W-1:0] ADDR_DATA   = 3'd0;
  localparam logic [ADDR_W-1:0] ADDR_SET    = 3'd1;
  localparam logic [ADDR_W-1:0] ADDR_CLR    = 3'd2;
  localparam logic [ADDR_W-1:0] ADDR_TGL    = 3'd3;
  localparam logic [ADDR_W-1:0] ADDR_MASK   = 3'd4;
  localparam logic [ADDR_W-1:0] ADDR_PERIOD = 3'd5;
  localparam logic [ADDR_W-1:0] ADDR_STATUS = 3'd6;

endpackage

// File: rtl/pio_out_blink_prescaler.sv
// Blink prescaler: counts PERIOD+1 clocks per half-period and toggles phase.
module blink_prescaler #(
  parameter int unsigned          PRESC_W      = 24,
  parameter logic [PRESC_W-1:0]   RESET_PERIOD = '0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [PRESC_W-1:0] period,
  input  logic               load,
  output logic               phase,
  output logic               phase_nxt
);

  logic [PRESC_W-1:0] cnt;
  logic [PRESC_W-1:0] cnt_nxt;

  // period carries the post-write value, so a load restarts from the new PERIOD
  always_comb begin
    cnt_nxt   = cnt;
    phase_nxt = phase;
    if (load) begin
      cnt_nxt   = period;
      phase_nxt = 1'b0;
    end else if (period == '0) begin
      cnt_nxt   = '0;
      phase_nxt = 1'b0;
    end else if (cnt == '0) begin
      cnt_nxt   = period;
      phase_nxt = ~phase;
    end else begin
      cnt_nxt   = cnt - PRESC_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt   <= RESET_PERIOD;
      phase <= 1'b0;
    end else begin
      cnt   <= cnt_nxt;
      phase <= phase_nxt;
    end
  end

endmodule

// File: rtl/pio_out_blink.sv
// Avalon-MM output PIO with atomic set/clear/toggle and per-bit blinking.
module pio_out_blink
  import pio_out_blink_pkg::*;
#(
  parameter int unsigned        WIDTH        = 9,
  parameter logic [WIDTH-1:0]   RESET_VALUE  = '0,
  parameter int unsigned        PRESC_W      = 24,
  parameter logic [PRESC_W-1:0] RESET_PERIOD = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic [WIDTH-1:0]  out_port
);

  logic               wr;
  logic [WIDTH-1:0]   wd;
  logic [WIDTH-1:0]   data_q, data_nxt;
  logic [WIDTH-1:0]   mask_q, mask_nxt;
  logic [PRESC_W-1:0] period_q, period_nxt;
  logic               period_load;
  logic               phase, phase_nxt;
  logic [WIDTH-1:0]   out_nxt;
  logic               unused_wd;

  assign wr        = chipselect & ~write_n;
  assign wd        = writedata[WIDTH-1:0];
  assign unused_wd = ^writedata;

  always_comb begin
    data_nxt    = data_q;
    mask_nxt    = mask_q;
    period_nxt  = period_q;
    period_load = 1'b0;
    if (wr) begin
      case (address)
        ADDR_DATA:   data_nxt = wd;
        ADDR_SET:    data_nxt = data_q | wd;
        ADDR_CLR:    data_nxt = data_q & ~wd;
        ADDR_TGL:    data_nxt = data_q ^ wd;
        ADDR_MASK:   mask_nxt = wd;
        ADDR_PERIOD: begin
          period_nxt  = writedata[PRESC_W-1:0];
          period_load = 1'b1;
        end
        default: ;
      endcase
    end
  end

  blink_prescaler #(
    .PRESC_W      (PRESC_W),
    .RESET_PERIOD (RESET_PERIOD)
  ) u_presc (
    .clk       (clk),
    .reset     (reset),
    .period    (period_nxt),
    .load      (period_load),
    .phase     (phase),
    .phase_nxt (phase_nxt)
  );

  // out_port is registered from next-state values so a same-cycle DATA write
  // and phase toggle land together on one edge
  assign out_nxt = data_nxt ^ (mask_nxt & {WIDTH{phase_nxt}});

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q   <= RESET_VALUE;
      mask_q   <= '0;
      period_q <= RESET_PERIOD;
      out_port <= RESET_VALUE;
    end else begin
      data_q   <= data_nxt;
      mask_q   <= mask_nxt;
      period_q <= period_nxt;
      out_port <= out_nxt;
    end
  end

  always_comb begin
    readdata = '0;
    case (address)
      ADDR_DATA:   readdata[WIDTH-1:0]   = data_q;
      ADDR_MASK:   readdata[WIDTH-1:0]   = mask_q;
      ADDR_PERIOD: readdata[PRESC_W-1:0] = period_q;
      ADDR_STATUS: readdata[0]           = phase;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_pio_out_blink.sv
// Bench for pio_out_blink: two parameterisations against a cycle-count blink model.
module tb_pio_out_blink;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [2:0]  address = '0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [31:0] rd0, rd1;
  logic [8:0]  out0;
  logic [31:0] out1;

  int n_cmp = 0;
  int n_bad = 0;
  bit run = 1'b0;

  always #5 clk = ~clk;

  pio_out_blink #(
    .WIDTH(9), .RESET_VALUE(9'h0A5), .PRESC_W(8), .RESET_PERIOD(8'd0)
  ) dut0 (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(rd0), .out_port(out0)
  );

  pio_out_blink #(
    .WIDTH(32), .RESET_VALUE(32'hDEAD_BEEF), .PRESC_W(32), .RESET_PERIOD(32'd2)
  ) dut1 (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(rd1), .out_port(out1)
  );

  localparam logic [31:0] WM [2] = '{32'h0000_01FF, 32'hFFFF_FFFF};
  localparam logic [31:0] PM [2] = '{32'h0000_00FF, 32'hFFFF_FFFF};
  localparam logic [31:0] RV [2] = '{32'h0000_00A5, 32'hDEAD_BEEF};
  localparam logic [31:0] RP [2] = '{32'd0, 32'd2};

  // Model: blink phase is derived from clocks elapsed since the last restart
  logic [31:0] m_data [2];
  logic [31:0] m_mask [2];
  logic [31:0] m_period [2];
  longint      m_k [2];

  function automatic logic m_phase(input int i);
    if (m_period[i] == 0) return 1'b0;
    return ((m_k[i] / (longint'(m_period[i]) + 1)) % 2) == 1;
  endfunction

  function automatic logic [31:0] m_out(input int i);
    return (m_data[i] ^ (m_mask[i] & {32{m_phase(i)}})) & WM[i];
  endfunction

  function automatic logic [31:0] m_read(input int i, input logic [2:0] a);
    case (a)
      3'd0:    return m_data[i];
      3'd4:    return m_mask[i];
      3'd5:    return m_period[i];
      3'd6:    return {31'b0, m_phase(i)};
      default: return 32'h0;
    endcase
  endfunction

  always @(posedge clk or posedge reset) begin
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        m_data[i]   <= RV[i];
        m_mask[i]   <= '0;
        m_period[i] <= RP[i];
        m_k[i]      <= 0;
      end else begin
        m_k[i] <= m_k[i] + 1;
        if (chipselect && !write_n) begin
          case (address)
            3'd0: m_data[i] <= writedata & WM[i];
            3'd1: m_data[i] <= m_data[i] | (writedata & WM[i]);
            3'd2: m_data[i] <= m_data[i] & ~(writedata & WM[i]);
            3'd3: m_data[i] <= m_data[i] ^ (writedata & WM[i]);
            3'd4: m_mask[i] <= writedata & WM[i];
            3'd5: begin
              m_period[i] <= writedata & PM[i];
              m_k[i]      <= 0;
            end
            default: ;
          endcase
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual %h required %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (run && !reset) begin
      chk("model_out0", 32'(out0), m_out(0));
      chk("model_out1", out1, m_out(1));
      chk("model_rd0", rd0, m_read(0, address));
      chk("model_rd1", rd1, m_read(1, address));
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    step();
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = $urandom;
  endtask

  task automatic rchk(input string nm, input logic [2:0] a, input logic [31:0] exp0);
    address = a;
    #1;
    chk(nm, rd0, exp0);
  endtask

  initial begin
    int r;
    #1 reset = 1'b1;
    #1;
    chk("rst_out0", 32'(out0), 32'h0A5);
    chk("rst_out1", out1, 32'hDEAD_BEEF);
    rchk("rst_rd_data", 3'd0, 32'h0000_00A5);
    rchk("rst_rd_mask", 3'd4, 32'h0);
    rchk("rst_rd_period", 3'd5, 32'h0);
    chk("rst_rd1_period", rd1, 32'd2);
    rchk("rst_rd_status", 3'd6, 32'h0);
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
    run = 1'b1;

    wr(3'd0, 32'hFFFF_F1FF);
    chk("data_wr_out", 32'(out0), 32'h1FF);
    rchk("data_wr_rd", 3'd0, 32'h1FF);
    wr(3'd1, 32'h000);
    chk("set_out", 32'(out0), 32'h1FF);
    wr(3'd2, 32'h00F);
    chk("clr_out", 32'(out0), 32'h1F0);
    wr(3'd3, 32'h101);
    chk("tgl_out", 32'(out0), 32'h0F1);

    wr(3'd0, 32'h0);
    wr(3'd4, 32'h3);
    wr(3'd5, 32'h3);
    for (int k = 0; k < 10; k++) begin
      chk("blink3_out", 32'(out0), ((k / 4) % 2 == 1) ? 32'h3 : 32'h0);
      rchk("blink3_status", 3'd6, ((k / 4) % 2 == 1) ? 32'h1 : 32'h0);
      step();
    end
    step();
    step();
    chk("midblink_phase1", 32'(out0), 32'h3);
    wr(3'd5, 32'h1);
    for (int k = 0; k < 6; k++) begin
      chk("blink1_out", 32'(out0), ((k / 2) % 2 == 1) ? 32'h3 : 32'h0);
      step();
    end
    wr(3'd0, 32'h0C0);
    wr(3'd5, 32'h0);
    for (int k = 0; k < 6; k++) begin
      chk("stopped_out", 32'(out0), 32'h0C0);
      step();
    end

    wr(3'd0, 32'h0);
    wr(3'd4, 32'h1);
    wr(3'd5, 32'h2);
    step();
    step();
    wr(3'd0, 32'h100);
    chk("coincide_out", 32'(out0), 32'h101);

    wr(3'd4, 32'h1F);
    wr(3'd0, 32'h0);
    wr(3'd5, 32'h3);
    repeat (5) step();
    chk("preRst_out", 32'(out0), 32'h1F);
    address    = 3'd0;
    writedata  = 32'h55;
    chipselect = 1'b1;
    write_n    = 1'b0;
    #1 reset = 1'b1;
    #1;
    chk("midRst_out0", 32'(out0), 32'h0A5);
    chk("midRst_out1", out1, 32'hDEAD_BEEF);
    reset      = 1'b0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    address    = 3'd6;
    for (int k = 1; k <= 6; k++) begin
      step();
      chk("postRst_phase1", rd1, ((k / 3) % 2 == 1) ? 32'h1 : 32'h0);
      chk("postRst_phase0", rd0, 32'h0);
      chk("postRst_out0", 32'(out0), 32'h0A5);
    end

    repeat (3000) begin
      step();
      r = $urandom_range(0, 99);
      address = 3'($urandom);
      if (r < 30) begin
        chipselect = 1'b1;
        write_n    = 1'b0;
        writedata  = (address == 3'd5) ? $urandom_range(0, 5) : $urandom;
      end else if (r < 31) begin
        chipselect = 1'b0;
        write_n    = 1'b1;
        #1 reset = 1'b1;
        #1 reset = 1'b0;
      end else begin
        chipselect = 1'($urandom);
        write_n    = 1'b1;
        writedata  = $urandom;
        if (r > 90) begin
          chipselect = 1'b0;
          write_n    = 1'b0;
        end
      end
    end
    step();
    chipselect = 1'b0;
    write_n    = 1'b1;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
